// File: rtl/prt_lb_tmo_if.sv
// Local-bus bridge signal bundle: upstream CPU request side, downstream mux side and error/stat outputs.
// slave is the bridge view; master is the environment view (CPU, bus mux, error handler).
interface prt_lb_tmo_if #(
    parameter int P_ADR_WIDTH = 22
);
    logic [P_ADR_WIDTH-1:0] UP_ADR_IN;
    logic                   UP_WR_IN;
    logic                   UP_RD_IN;
    logic [31:0]            UP_DAT_IN;
    logic [31:0]            UP_DAT_OUT;
    logic                   UP_ACK_OUT;
    logic [P_ADR_WIDTH-1:0] DWN_ADR_OUT;
    logic                   DWN_WR_OUT;
    logic                   DWN_RD_OUT;
    logic [31:0]            DWN_DAT_OUT;
    logic [31:0]            DWN_DAT_IN;
    logic                   DWN_VLD_IN;
    logic                   ERR_CLR_IN;
    logic                   ERR_OUT;
    logic [P_ADR_WIDTH-1:0] ERR_ADR_OUT;
    logic                   IRQ_OUT;
    logic [15:0]            TMO_CNT_OUT;

    modport slave (
        input  UP_ADR_IN, UP_WR_IN, UP_RD_IN, UP_DAT_IN, DWN_DAT_IN, DWN_VLD_IN, ERR_CLR_IN,
        output UP_DAT_OUT, UP_ACK_OUT, DWN_ADR_OUT, DWN_WR_OUT, DWN_RD_OUT, DWN_DAT_OUT,
               ERR_OUT, ERR_ADR_OUT, IRQ_OUT, TMO_CNT_OUT
    );

    modport master (
        output UP_ADR_IN, UP_WR_IN, UP_RD_IN, UP_DAT_IN, DWN_DAT_IN, DWN_VLD_IN, ERR_CLR_IN,
        input  UP_DAT_OUT, UP_ACK_OUT, DWN_ADR_OUT, DWN_WR_OUT, DWN_RD_OUT, DWN_DAT_OUT,
               ERR_OUT, ERR_ADR_OUT, IRQ_OUT, TMO_CNT_OUT
    );
endinterface

// File: rtl/prt_lb_tmo.sv
// Local-bus bridge with read timeout: write ack 2 cycles after request, timed-out read acks P_TMO+1 cycles after DWN_RD_OUT.
// Level requests are held until ack (no other backpressure); PRT_LB_TMO_STAT_EN enables the TMO_CNT_OUT timeout counter.
module prt_lb_tmo #(
    parameter int          P_ADR_WIDTH = 22,
    parameter int          P_TMO       = 255,
    parameter logic [31:0] P_ERR_DAT   = 32'hDEAD_BEEF
) (
    input logic          CLK_IN,
    input logic          RST_IN,
    prt_lb_tmo_if.slave  lb
);
    localparam logic [15:0] TMO_LOAD = 16'(P_TMO);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [15:0]            tmo_cnt_dn;
    logic [31:0]            up_dat;
    logic                   up_ack;
    logic [P_ADR_WIDTH-1:0] dwn_adr;
    logic [31:0]            dwn_dat;
    logic                   dwn_wr;
    logic                   dwn_rd;
    logic                   err;
    logic [P_ADR_WIDTH-1:0] err_adr;
    logic                   irq;
    logic                   tmo_hit;

    // Valid data in the same cycle as an expiring counter wins, so a timeout needs vld low.
    assign tmo_hit = (state == S_RD_WAIT) && !lb.DWN_VLD_IN && (tmo_cnt_dn == 16'd0);

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state      <= S_IDLE;
            tmo_cnt_dn <= 16'd0;
            up_dat     <= 32'd0;
            up_ack     <= 1'b0;
            dwn_adr    <= '0;
            dwn_dat    <= 32'd0;
            dwn_wr     <= 1'b0;
            dwn_rd     <= 1'b0;
            err        <= 1'b0;
            err_adr    <= '0;
            irq        <= 1'b0;
        end else begin
            dwn_wr <= 1'b0;
            dwn_rd <= 1'b0;
            up_ack <= 1'b0;
            irq    <= 1'b0;
            if (lb.ERR_CLR_IN) begin
                err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (lb.UP_WR_IN) begin
                        dwn_adr <= lb.UP_ADR_IN;
                        dwn_dat <= lb.UP_DAT_IN;
                        dwn_wr  <= 1'b1;
                        state   <= S_WR;
                    end else if (lb.UP_RD_IN) begin
                        dwn_adr    <= lb.UP_ADR_IN;
                        dwn_rd     <= 1'b1;
                        tmo_cnt_dn <= TMO_LOAD;
                        state      <= S_RD_WAIT;
                    end
                end
                S_WR: begin
                    up_ack <= 1'b1;
                    state  <= S_DONE;
                end
                S_RD_WAIT: begin
                    if (lb.DWN_VLD_IN) begin
                        up_dat <= lb.DWN_DAT_IN;
                        up_ack <= 1'b1;
                        state  <= S_DONE;
                    end else if (tmo_hit) begin
                        up_dat <= P_ERR_DAT;
                        up_ack <= 1'b1;
                        irq    <= 1'b1;
                        err    <= 1'b1;
                        // Only the first timeout since the last clear is recorded.
                        if (!err) begin
                            err_adr <= dwn_adr;
                        end
                        state  <= S_DONE;
                    end else begin
                        tmo_cnt_dn <= tmo_cnt_dn - 16'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PRT_LB_TMO_STAT_EN
    logic [15:0] tmo_stat;

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            tmo_stat <= 16'd0;
        end else if (tmo_hit) begin
            if (lb.ERR_CLR_IN) begin
                tmo_stat <= 16'd1;
            end else if (tmo_stat != 16'hFFFF) begin
                tmo_stat <= tmo_stat + 16'd1;
            end
        end else if (lb.ERR_CLR_IN) begin
            tmo_stat <= 16'd0;
        end
    end

    assign lb.TMO_CNT_OUT = tmo_stat;
`else
    assign lb.TMO_CNT_OUT = 16'd0;
`endif

    assign lb.UP_DAT_OUT  = up_dat;
    assign lb.UP_ACK_OUT  = up_ack;
    assign lb.DWN_ADR_OUT = dwn_adr;
    assign lb.DWN_DAT_OUT = dwn_dat;
    assign lb.DWN_WR_OUT  = dwn_wr;
    assign lb.DWN_RD_OUT  = dwn_rd;
    assign lb.ERR_OUT     = err;
    assign lb.ERR_ADR_OUT = err_adr;
    assign lb.IRQ_OUT     = irq;
endmodule

// File: tb/tb_prt_lb_tmo.sv
// Bench for prt_lb_tmo: directed and random reads/writes against a transaction-level model of acks, timeouts and error state.
module tb_prt_lb_tmo;
    localparam int          AW    = 22;
    localparam int          P_TMO = 255;
    localparam logic [31:0] P_ERR = 32'hDEAD_BEEF;

    logic CLK_IN = 1'b0;
    logic RST_IN = 1'b1;

    prt_lb_tmo_if #(.P_ADR_WIDTH(AW)) bus ();

    prt_lb_tmo #(
        .P_ADR_WIDTH(AW),
        .P_TMO      (P_TMO),
        .P_ERR_DAT  (P_ERR)
    ) dut (
        .CLK_IN(CLK_IN),
        .RST_IN(RST_IN),
        .lb    (bus.slave)
    );

    always #5 CLK_IN = ~CLK_IN;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference error state, updated per completed transaction.
    logic          exp_err     = 1'b0;
    logic [AW-1:0] exp_err_adr = '0;
    logic [15:0]   exp_cnt     = 16'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic model_timeout(input logic [AW-1:0] adr, input bit clr_same);
        if (!exp_err) exp_err_adr = adr;
        exp_err = 1'b1;
`ifdef PRT_LB_TMO_STAT_EN
        if (clr_same)                 exp_cnt = 16'd1;
        else if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`else
        if (clr_same) exp_cnt = 16'd0;
`endif
    endtask

    task automatic model_clear();
        exp_err = 1'b0;
        exp_cnt = 16'd0;
    endtask

    task automatic check_err_state(input string tag);
        check({tag, "_err"},     64'(bus.ERR_OUT),     64'(exp_err));
        check({tag, "_err_adr"}, 64'(bus.ERR_ADR_OUT), 64'(exp_err_adr));
        check({tag, "_tmo_cnt"}, 64'(bus.TMO_CNT_OUT), 64'(exp_cnt));
    endtask

    // Write: strobe in the cycle after the request, ack one cycle later.
    task automatic do_write(input logic [AW-1:0] adr, input logic [31:0] dat, input bit rd_too);
        int n_wr, n_rd, n_ack, wr_k, ack_k;
        bit drop;
        n_wr = 0; n_rd = 0; n_ack = 0; wr_k = -1; ack_k = -1; drop = 0;
        bus.UP_ADR_IN = adr;
        bus.UP_DAT_IN = dat;
        bus.UP_WR_IN  = 1'b1;
        bus.UP_RD_IN  = rd_too;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (drop) begin
                bus.UP_WR_IN = 1'b0;
                bus.UP_RD_IN = 1'b0;
            end
            if (bus.DWN_WR_OUT) begin n_wr++; if (wr_k < 0) wr_k = k; end
            if (bus.DWN_RD_OUT) n_rd++;
            if (bus.UP_ACK_OUT) begin n_ack++; if (ack_k < 0) ack_k = k; drop = 1; end
        end
        check("wr_strobe_cycle", 64'(wr_k), 64'(1));
        check("wr_strobe_count", 64'(n_wr), 64'(1));
        check("wr_no_rd_strobe", 64'(n_rd), 64'(0));
        check("wr_ack_cycle",    64'(ack_k), 64'(2));
        check("wr_ack_count",    64'(n_ack), 64'(1));
        check("wr_adr_hold",     64'(bus.DWN_ADR_OUT), 64'(adr));
        check("wr_dat_hold",     64'(bus.DWN_DAT_OUT), 64'(dat));
    endtask

    // Read: d = cycles after the DWN_RD_OUT cycle at which vld arrives (-1: never); clr_k = cycle holding ERR_CLR_IN (0: none).
    task automatic do_read(input logic [AW-1:0] adr, input int d, input logic [31:0] rdat, input int clr_k);
        int n_rd, n_ack, n_irq, ack_k, irq_k, last_k, exp_ack_k;
        bit exp_tmo, drop;
        logic [31:0] got_dat, exp_dat;
        logic [AW-1:0] rd_adr;
        n_rd = 0; n_ack = 0; n_irq = 0; ack_k = -1; irq_k = -1; drop = 0;
        got_dat = 'x; rd_adr = 'x;
        // Valid data counts if it arrives no later than the cycle in which P_TMO cycles have elapsed.
        exp_tmo   = (d < 0) || (d > P_TMO);
        exp_ack_k = exp_tmo ? P_TMO + 2 : d + 2;
        exp_dat   = exp_tmo ? P_ERR : rdat;
        last_k    = ((exp_ack_k > d + 1) ? exp_ack_k : d + 1) + 3;
        bus.UP_ADR_IN = adr;
        bus.UP_RD_IN  = 1'b1;
        for (int k = 1; k <= last_k; k++) begin
            tick();
            if (drop) bus.UP_RD_IN = 1'b0;
            bus.DWN_VLD_IN = (k == d + 1);
            bus.DWN_DAT_IN = (k == d + 1) ? rdat : $urandom;
            bus.ERR_CLR_IN = (k == clr_k);
            if (bus.DWN_RD_OUT) begin n_rd++; rd_adr = bus.DWN_ADR_OUT; end
            if (bus.UP_ACK_OUT) begin
                n_ack++;
                if (ack_k < 0) begin ack_k = k; got_dat = bus.UP_DAT_OUT; end
                drop = 1;
            end
            if (bus.IRQ_OUT) begin n_irq++; if (irq_k < 0) irq_k = k; end
        end
        bus.DWN_VLD_IN = 1'b0;
        bus.ERR_CLR_IN = 1'b0;
        if (exp_tmo)        model_timeout(adr, clr_k == P_TMO + 1);
        else if (clr_k > 0) model_clear();
        check("rd_strobe_count", 64'(n_rd), 64'(1));
        check("rd_strobe_adr",   64'(rd_adr), 64'(adr));
        check("rd_ack_cycle",    64'(ack_k), 64'(exp_ack_k));
        check("rd_ack_count",    64'(n_ack), 64'(1));
        check("rd_data",         64'(got_dat), 64'(exp_dat));
        check("rd_irq_count",    64'(n_irq), 64'(exp_tmo ? 1 : 0));
        if (exp_tmo) check("rd_irq_cycle", 64'(irq_k), 64'(exp_ack_k));
        check_err_state("rd");
    endtask

    task automatic clear_err();
        bus.ERR_CLR_IN = 1'b1;
        tick();
        bus.ERR_CLR_IN = 1'b0;
        model_clear();
        check_err_state("clr");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_up_dat"},  64'(bus.UP_DAT_OUT),  64'(0));
        check({tag, "_up_ack"},  64'(bus.UP_ACK_OUT),  64'(0));
        check({tag, "_dwn_adr"}, 64'(bus.DWN_ADR_OUT), 64'(0));
        check({tag, "_dwn_dat"}, 64'(bus.DWN_DAT_OUT), 64'(0));
        check({tag, "_strobes"}, 64'({bus.DWN_WR_OUT, bus.DWN_RD_OUT}), 64'(0));
        check({tag, "_irq"},     64'(bus.IRQ_OUT),     64'(0));
        check({tag, "_err"},     64'(bus.ERR_OUT),     64'(0));
        check({tag, "_err_adr"}, 64'(bus.ERR_ADR_OUT), 64'(0));
        check({tag, "_tmo_cnt"}, 64'(bus.TMO_CNT_OUT), 64'(0));
    endtask

    initial begin
        logic [AW-1:0] adr;
        logic [31:0]   dat;
        int            d, n_ack, n_irq;

        bus.UP_ADR_IN = '0; bus.UP_WR_IN = 1'b0; bus.UP_RD_IN = 1'b0; bus.UP_DAT_IN = '0;
        bus.DWN_DAT_IN = '0; bus.DWN_VLD_IN = 1'b0; bus.ERR_CLR_IN = 1'b0;

        // Step 1: reset values.
        #1;
        check_reset_outputs("init");
        repeat (2) tick();
        RST_IN = 1'b0;
        tick();

        // Step 2: directed write.
        do_write(22'h00100, 32'h1234_5678, 1'b0);

        // Step 3: read answered 3 cycles after the strobe.
        do_read(22'h00140, 3, 32'hA5A5_0001, 0);

        // Step 4: unmapped read times out, first error address captured.
        do_read(22'h3FFFF, -1, 32'h0, 0);

        // Step 5: second timeout keeps the first address; then clear.
        do_read(22'h00200, -1, 32'h0, 0);
        clear_err();

        // Step 6: vld coincident with the expiring counter returns data.
        do_read(22'h00321, P_TMO, 32'h0BAD_F00D, 0);

        // Step 7: vld two cycles after a timeout ack is ignored.
        do_read(22'h00444, P_TMO + 3, 32'h1111_2222, 0);

        // Step 8: simultaneous write and read requests, write wins.
        do_write(22'h2AAAA, 32'hCAFE_0008, 1'b1);

        // Step 9: clear coincident with a timeout, set wins.
        do_read(22'h00555, -1, 32'h0, P_TMO + 1);
        clear_err();

        // Step 10: randomized traffic around the interesting points.
        for (int i = 0; i < 20; i++) begin
            adr = AW'($urandom);
            dat = $urandom;
            case ($urandom_range(0, 3))
                0: do_write(adr, dat, 1'($urandom_range(0, 1)));
                1, 2: do_read(adr, int'($urandom_range(0, 12)), dat, 0);
                default: begin
                    d = ($urandom_range(0, 1) == 1) ? -1 : P_TMO - 1 + int'($urandom_range(0, 2));
                    do_read(adr, d, dat, 0);
                end
            endcase
            repeat ($urandom_range(0, 2)) tick();
        end

        // Step 11: reset in the middle of a read abandons it.
        do_read(22'h01234, -1, 32'h0, 0);
        do_write(22'h00777, 32'h7777_7777, 1'b0);
        bus.UP_ADR_IN = 22'h0ABCD;
        bus.UP_RD_IN  = 1'b1;
        repeat (4) tick();
        #2;
        RST_IN = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        bus.UP_RD_IN = 1'b0;
        tick();
        RST_IN = 1'b0;
        exp_err = 1'b0; exp_err_adr = '0; exp_cnt = 16'd0;
        n_ack = 0; n_irq = 0;
        for (int k = 0; k < P_TMO + 8; k++) begin
            tick();
            if (bus.UP_ACK_OUT) n_ack++;
            if (bus.IRQ_OUT)    n_irq++;
        end
        check("rst_no_ack", 64'(n_ack), 64'(0));
        check("rst_no_irq", 64'(n_irq), 64'(0));
        do_read(22'h00ABC, 5, 32'h5A5A_1234, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
